// File: rtl/summ_pkg.sv
// Shared definitions for the apodized delay-and-sum summer.
//   state_t      : FSM state encoding (IDLE, ACCUM, DRAIN, OUT)
//   acc_width()  : accumulator width that cannot wrap for a full sum
//   cnt_width()  : beat counter width able to hold 0..MAX_BEATS
//   ch_width()   : channel index width, never below one bit
//   sat_hi/lo()  : clamp bounds of a signed output of a given width
package summ_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Product is DATA+COEF+1 bits (weight gains a zero sign bit); summing up to
  // MAX_BEATS of them needs clog2(MAX_BEATS) extra bits of headroom.
  function automatic int acc_width(input int dw, input int cw, input int mb);
    return dw + cw + 1 + $clog2(mb);
  endfunction

  function automatic int cnt_width(input int mb);
    return $clog2(mb + 1);
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic longint sat_hi(input int ow);
    return (longint'(1) <<< (ow - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int ow);
    return -(longint'(1) <<< (ow - 1));
  endfunction

endpackage

// File: rtl/apod_mul.sv
// One-stage registered signed-by-unsigned multiplier.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_valid      : operands valid this cycle
//   i_sample     : signed sample
//   i_weight     : unsigned weight (treated as a non-negative signed value)
//   o_valid      : product valid (one cycle after i_valid)
//   o_prod       : registered signed product
module apod_mul #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                i_valid,
  input  logic signed [DATA_WIDTH-1:0]        i_sample,
  input  logic        [COEF_WIDTH-1:0]        i_weight,
  output logic                                o_valid,
  output logic signed [DATA_WIDTH+COEF_WIDTH:0] o_prod
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;

  logic signed [COEF_WIDTH:0] w_weight_s;
  logic signed [PW-1:0]       w_prod;

  // Zero-extend the weight so the multiply stays signed without flipping it.
  assign w_weight_s = $signed({1'b0, i_weight});
  assign w_prod     = PW'(i_sample) * PW'(w_weight_s);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_prod  <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) o_prod <= w_prod;
    end
  end

endmodule

// File: rtl/summ_sa_apod.sv
// Apodized summer: weights each accepted sample by its channel's weight,
// accumulates a sum of up to MAX_BEATS beats and presents it saturated.
//   clk, reset_n               : clock, asynchronous active-low reset
//   start_sum                  : open a new sum (aborts one in progress)
//   s_valid/s_ready/s_sample/s_chan/s_last : sample stream
//   coef_we/coef_addr/coef_data: weight register write port
//   m_valid/m_ready/m_sum/m_count/m_sat/m_trunc : result stream
//   busy                       : not idle
module summ_sa_apod
  import summ_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int COEF_WIDTH   = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int MAX_BEATS    = 64,
  parameter int OUT_WIDTH    = 24,
  localparam int CH_W        = ch_width(NUM_CHANNELS),
  localparam int CNT_W       = cnt_width(MAX_BEATS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start_sum,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_sample,
  input  logic        [CH_W-1:0]      s_chan,
  input  logic                        s_last,
  input  logic                        coef_we,
  input  logic        [CH_W-1:0]      coef_addr,
  input  logic        [COEF_WIDTH-1:0] coef_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [OUT_WIDTH-1:0] m_sum,
  output logic        [CNT_W-1:0]     m_count,
  output logic                        m_sat,
  output logic                        m_trunc,
  output logic                        busy
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEF_WIDTH, MAX_BEATS);
  localparam int PW        = DATA_WIDTH + COEF_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_hi(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_lo(OUT_WIDTH));

  state_t                       r_state;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic        [CNT_W-1:0]      r_cnt;
  logic                         r_trunc_pend;
  logic        [COEF_WIDTH-1:0] r_weight [NUM_CHANNELS];
  logic                         r_m_valid;
  logic signed [OUT_WIDTH-1:0]  r_m_sum;
  logic        [CNT_W-1:0]      r_m_count;
  logic                         r_m_sat;
  logic                         r_m_trunc;

  logic                         w_s_ready;
  logic                         w_fire;
  logic                         w_mul_in;
  logic        [COEF_WIDTH-1:0] w_weight;
  logic                         w_prod_valid;
  logic signed [PW-1:0]         w_prod;
  logic signed [ACC_WIDTH-1:0]  w_acc_sum;
  logic                         w_hi;
  logic                         w_lo;
  logic signed [OUT_WIDTH-1:0]  w_clamped;
  logic                         w_end;

  assign w_s_ready = (r_state == ST_ACCUM);
  assign w_fire    = s_valid && w_s_ready;
  // A beat that coincides with an abort never enters the pipeline.
  assign w_mul_in  = w_fire && !start_sum;
  assign w_end     = s_last || (r_cnt == CNT_W'(MAX_BEATS - 1));

  // Weight lookup; channels with no register read as weight 0.
  always_comb begin
    w_weight = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (s_chan == CH_W'(i)) w_weight = r_weight[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) r_weight[i] <= '0;
    end else if (coef_we) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (coef_addr == CH_W'(i)) r_weight[i] <= coef_data;
      end
    end
  end

  apod_mul #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH)
  ) u_mul (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_valid  (w_mul_in),
    .i_sample (s_sample),
    .i_weight (w_weight),
    .o_valid  (w_prod_valid),
    .o_prod   (w_prod)
  );

  assign w_acc_sum = r_acc + ACC_WIDTH'(w_prod);
  assign w_hi      = (r_acc > SAT_HI);
  assign w_lo      = (r_acc < SAT_LO);
  assign w_clamped = w_hi ? OUT_WIDTH'(SAT_HI) :
                     w_lo ? OUT_WIDTH'(SAT_LO) : OUT_WIDTH'(r_acc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_trunc_pend <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_sum      <= '0;
      r_m_count    <= '0;
      r_m_sat      <= 1'b0;
      r_m_trunc    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_sum) begin
            r_state      <= ST_ACCUM;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_trunc_pend <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (start_sum) begin
            // Abort: the in-flight product is dropped by not adding it.
            r_acc <= '0;
            r_cnt <= '0;
          end else begin
            if (w_prod_valid) r_acc <= w_acc_sum;
            if (w_fire) begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (w_end) begin
                r_state      <= ST_DRAIN;
                r_trunc_pend <= !s_last;
              end
            end
          end
        end
        ST_DRAIN: begin
          // Stay until the last product has been folded into the sum,
          // then register the result from the settled accumulator.
          if (w_prod_valid) begin
            r_acc <= w_acc_sum;
          end else begin
            r_state   <= ST_OUT;
            r_m_valid <= 1'b1;
            r_m_sum   <= w_clamped;
            r_m_sat   <= w_hi || w_lo;
            r_m_count <= r_cnt;
            r_m_trunc <= r_trunc_pend;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            if (start_sum) begin
              r_state      <= ST_ACCUM;
              r_acc        <= '0;
              r_cnt        <= '0;
              r_trunc_pend <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready = w_s_ready;
  assign busy    = (r_state != ST_IDLE);
  assign m_valid = r_m_valid;
  assign m_sum   = r_m_sum;
  assign m_count = r_m_count;
  assign m_sat   = r_m_sat;
  assign m_trunc = r_m_trunc;

endmodule

// File: tb/tb_summ_sa_apod.sv
module tb_summ_sa_apod;

  localparam int MAXB = 64;
  localparam longint HI = (longint'(1) <<< 23) - 1;
  localparam longint LO = -(longint'(1) <<< 23);

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start_sum = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic signed [15:0] s_sample = '0;
  logic [1:0]         s_chan = '0;
  logic               s_last = 1'b0;
  logic               coef_we = 1'b0;
  logic [1:0]         coef_addr = '0;
  logic [7:0]         coef_data = '0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic signed [23:0] m_sum;
  logic [6:0]         m_count;
  logic               m_sat;
  logic               m_trunc;
  logic               busy;

  int total = 0;
  int bad   = 0;

  // Reference model: weights and the open sum, as plain numbers.
  int     wm [4];
  longint mdl_sum;
  int     mdl_cnt;
  bit     mdl_open;
  bit     mdl_trunc;

  always #5 clk = ~clk;

  summ_sa_apod dut (
    .clk(clk), .reset_n(reset_n), .start_sum(start_sum),
    .s_valid(s_valid), .s_ready(s_ready), .s_sample(s_sample),
    .s_chan(s_chan), .s_last(s_last),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum),
    .m_count(m_count), .m_sat(m_sat), .m_trunc(m_trunc), .busy(busy)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic mdl_clear(input bit open);
    mdl_sum = 0; mdl_cnt = 0; mdl_open = open; mdl_trunc = 0;
  endtask

  task automatic wr_coef(input int ch, input int val);
    @(negedge clk);
    s_valid = 0; start_sum = 0;
    coef_we = 1; coef_addr = ch[1:0]; coef_data = val[7:0];
    @(posedge clk);
    wm[ch] = val;
    @(negedge clk);
    coef_we = 0;
  endtask

  task automatic start_cmd();
    @(negedge clk);
    s_valid = 0; coef_we = 0; start_sum = 1;
    @(posedge clk);
    mdl_clear(1);
  endtask

  // One offered beat, optionally with a simultaneous weight write.
  task automatic drive_beat(input int smp, input int ch, input bit last,
                            input bit wr, input int wch, input int wval);
    bit acc;
    bit exp_acc;
    @(negedge clk);
    start_sum = 0;
    s_valid = 1; s_sample = smp[15:0]; s_chan = ch[1:0]; s_last = last;
    coef_we = wr; coef_addr = wch[1:0]; coef_data = wval[7:0];
    acc = s_ready;
    exp_acc = mdl_open && (mdl_cnt < MAXB);
    chk("beat_accept", acc, exp_acc);
    @(posedge clk);
    if (exp_acc) begin
      mdl_sum += longint'(smp) * wm[ch];
      mdl_cnt++;
      if (last || mdl_cnt == MAXB) begin
        mdl_open  = 0;
        mdl_trunc = !last;
      end
    end
    if (wr) wm[wch] = wval;
  endtask

  task automatic quiet();
    @(negedge clk);
    s_valid = 0; s_last = 0; coef_we = 0; start_sum = 0;
  endtask

  task automatic wait_valid(input string tag, output bit ok);
    int k = 0;
    while (m_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = (m_valid === 1'b1);
    if (!ok) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_fields(input string tag);
    longint e;
    e = (mdl_sum > HI) ? HI : (mdl_sum < LO) ? LO : mdl_sum;
    chk({tag, "_sum"},   m_sum, e);
    chk({tag, "_count"}, m_count, mdl_cnt);
    chk({tag, "_sat"},   m_sat, (mdl_sum > HI) || (mdl_sum < LO));
    chk({tag, "_trunc"}, m_trunc, mdl_trunc);
  endtask

  task automatic handshake(input string tag);
    m_ready = 1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 0;
    chk({tag, "_done"}, m_valid, 0);
  endtask

  task automatic get_result(input string tag);
    bit ok;
    quiet();
    wait_valid(tag, ok);
    if (ok) begin
      check_fields(tag);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      handshake(tag);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_sum"},   m_sum, 0);
    chk({tag, "_m_count"}, m_count, 0);
    chk({tag, "_m_sat"},   m_sat, 0);
    chk({tag, "_m_trunc"}, m_trunc, 0);
    chk({tag, "_busy"},    busy, 0);
  endtask

  initial begin : main
    bit ok;
    logic [63:0] snap;
    for (int i = 0; i < 4; i++) wm[i] = 0;
    mdl_clear(0);

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1;

    // Weighted sum and result latency.
    wr_coef(0, 255); wr_coef(1, 128); wr_coef(2, 64); wr_coef(3, 0);
    start_cmd();
    for (int i = 0; i < 4; i++) drive_beat(1000, i, i == 3, 0, 0, 0);
    quiet();
    chk("lat_edge1", m_valid, 0);
    chk("busy_drain", busy, 1);
    @(negedge clk);
    chk("lat_edge2", m_valid, 0);
    @(negedge clk);
    chk("lat_edge3", m_valid, 1);
    chk("t1_sum_const", m_sum, 447000);
    get_result("t1");

    // Saturation at both rails.
    for (int i = 0; i < 4; i++) wr_coef(i, 255);
    start_cmd();
    for (int i = 0; i < 4; i++) drive_beat(32767, i, i == 3, 0, 0, 0);
    get_result("sat_pos");
    chk("sat_pos_const", mdl_sum > HI, 1);
    start_cmd();
    for (int i = 0; i < 4; i++) drive_beat(-32768, i, i == 3, 0, 0, 0);
    get_result("sat_neg");

    // Forced end at MAX_BEATS; extra beats refused.
    wr_coef(0, 1);
    start_cmd();
    for (int i = 0; i < 70; i++) drive_beat(1, 0, 0, 0, 0, 0);
    get_result("trunc");
    chk("trunc_count_const", mdl_cnt, 64);

    // Back-pressure hold, then zero-bubble restart from the handshake cycle.
    start_cmd();
    drive_beat(-1234, 1, 0, 0, 0, 0);
    drive_beat(4321, 2, 1, 0, 0, 0);
    quiet();
    wait_valid("hold", ok);
    if (ok) begin
      check_fields("hold");
      snap = {m_sum, 7'(m_count), m_sat, m_trunc};
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("hold_stable", {m_sum, 7'(m_count), m_sat, m_trunc, m_valid},
            {snap, 1'b1});
        chk("hold_s_ready", s_ready, 0);
      end
      m_ready = 1; start_sum = 1;
      @(posedge clk);
      mdl_clear(1);
      @(negedge clk);
      m_ready = 0; start_sum = 0;
      chk("zb_m_valid", m_valid, 0);
      chk("zb_s_ready", s_ready, 1);
      drive_beat(77, 0, 1, 0, 0, 0);
      get_result("zb");
    end

    // Abort mid-sum, including a beat offered in the abort cycle.
    start_cmd();
    for (int i = 0; i < 3; i++) drive_beat(500, 0, 0, 0, 0, 0);
    @(negedge clk);
    start_sum = 1; s_valid = 1; s_sample = 16'sd999; s_chan = 0; s_last = 0;
    @(posedge clk);
    mdl_clear(1);
    drive_beat(7, 0, 0, 0, 0, 0);
    drive_beat(7, 0, 1, 0, 0, 0);
    get_result("abort");
    chk("abort_sum_const", mdl_sum, 14);

    // Asynchronous reset in the middle of a sum.
    start_cmd();
    drive_beat(300, 0, 0, 0, 0, 0);
    drive_beat(300, 1, 0, 0, 0, 0);
    @(negedge clk);
    s_valid = 0;
    reset_n = 0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 4; i++) wm[i] = 0;
    mdl_clear(0);
    repeat (3) @(negedge clk);
    chk("post_rst_valid", m_valid, 0);
    chk("post_rst_busy", busy, 0);
    drive_beat(5, 0, 1, 0, 0, 0);   // offered in IDLE, refused
    quiet();
    // Weights must have been cleared: a sum with no writes is zero.
    start_cmd();
    drive_beat(12345, 2, 1, 0, 0, 0);
    get_result("rst_weights");

    // Randomized sums with weight writes landing on beats.
    for (int i = 0; i < 4; i++) wr_coef(i, $urandom_range(0, 255));
    for (int s = 0; s < 25; s++) begin
      int n;
      n = $urandom_range(1, 8);
      start_cmd();
      for (int b = 0; b < n; b++) begin
        drive_beat(int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 3),
                   b == n - 1, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3), $urandom_range(0, 255));
      end
      get_result("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
